// File: rtl/audio_fifo_bank.sv
// audio_fifo_bank: CHANNELS lock-stepped circular sample FIFOs feeding the dsp_unit.
// A play tick pops one aligned frame; underrun, overflow and refill flags are sticky.
module audio_fifo_bank #(
  parameter int CHANNELS      = 2,
  parameter int DATA_WIDTH    = 24,
  parameter int FIFO_DEPTH    = 60,
  parameter int IRQ_THRESHOLD = FIFO_DEPTH / 2,
  localparam int LW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS-1:0]            wr_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] wdata_in,
  input  logic                           tick_in,
  input  logic                           play_in,
  input  logic                           clr_in,
  input  logic                           irq_ack_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] audio_out,
  output logic                           valid_out,
  output logic [CHANNELS*LW-1:0]         level_out,
  output logic [CHANNELS-1:0]            full_out,
  output logic [CHANNELS-1:0]            empty_out,
  output logic [CHANNELS-1:0]            ovf_out,
  output logic                           nodata_out,
  output logic                           req_out
);

  localparam logic [PW-1:0] P_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] L_THR  = LW'(IRQ_THRESHOLD);

  logic [DATA_WIDTH-1:0] r_mem [CHANNELS][FIFO_DEPTH];

  logic [PW-1:0] r_wptr  [CHANNELS];
  logic [PW-1:0] r_rptr  [CHANNELS];
  logic [LW-1:0] r_level [CHANNELS];

  logic [CHANNELS-1:0]            r_full;
  logic [CHANNELS-1:0]            r_empty;
  logic [CHANNELS-1:0]            r_ovf;
  logic                           r_nodata;
  logic                           r_req;
  logic                           r_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] r_audio;

  logic                           w_tick;
  logic                           w_pop;
  logic                           w_under;
  logic                           w_req_set;
  logic [CHANNELS-1:0]            w_wr;
  logic [LW-1:0]                  w_lvl_nx [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] w_frame;

  assign w_tick  = tick_in & play_in & ~clr_in;
  assign w_pop   = w_tick & ~(|r_empty);
  assign w_under = w_tick & (|r_empty);

  always_comb begin
    w_wr      = '0;
    w_req_set = 1'b0;
    w_frame   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_wr[c] = wr_in[c] & ~clr_in & (~r_full[c] | w_pop);
      w_lvl_nx[c] = r_level[c];
      unique case ({w_wr[c], w_pop})
        2'b10:   w_lvl_nx[c] = r_level[c] + 1'b1;
        2'b01:   w_lvl_nx[c] = r_level[c] - 1'b1;
        default: w_lvl_nx[c] = r_level[c];
      endcase
      // Only a net decrease can cross the threshold downwards.
      if (w_pop && r_level[c] > L_THR && w_lvl_nx[c] <= L_THR)
        w_req_set = 1'b1;
      w_frame[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[c][r_rptr[c]];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      if (w_wr[c])
        r_mem[c][r_wptr[c]] <= wdata_in[c*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_level[c] <= '0;
      end
      r_full   <= '0;
      r_empty  <= '1;
      r_ovf    <= '0;
      r_nodata <= 1'b0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_audio  <= '0;
    end else if (clr_in) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_level[c] <= '0;
      end
      r_full   <= '0;
      r_empty  <= '1;
      r_ovf    <= '0;
      r_nodata <= 1'b0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_audio  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wr[c])
          r_wptr[c] <= (r_wptr[c] == P_LAST) ? '0 : r_wptr[c] + 1'b1;
        if (w_pop)
          r_rptr[c] <= (r_rptr[c] == P_LAST) ? '0 : r_rptr[c] + 1'b1;
        r_level[c] <= w_lvl_nx[c];
        r_full[c]  <= (w_lvl_nx[c] == L_FULL);
        r_empty[c] <= (w_lvl_nx[c] == '0);
        if (wr_in[c] && r_full[c] && !w_pop)
          r_ovf[c] <= 1'b1;
      end
      if (w_under)
        r_nodata <= 1'b1;
      if (w_req_set)
        r_req <= 1'b1;
      else if (irq_ack_in)
        r_req <= 1'b0;
      r_valid <= w_tick;
      if (w_pop)
        r_audio <= w_frame;
      else if (w_under)
        r_audio <= '0;
    end
  end

  always_comb begin
    level_out = '0;
    for (int c = 0; c < CHANNELS; c++)
      level_out[c*LW +: LW] = r_level[c];
  end

  assign audio_out  = r_audio;
  assign valid_out  = r_valid;
  assign full_out   = r_full;
  assign empty_out  = r_empty;
  assign ovf_out    = r_ovf;
  assign nodata_out = r_nodata;
  assign req_out    = r_req;

endmodule

// File: tb/tb_audio_fifo_bank.sv
// tb_audio_fifo_bank: directed vectors with a frame scoreboard.
// The stimulus pushes expected frames; a negedge monitor pops them on valid_out.
module tb_audio_fifo_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wr_in = '0;
  logic [47:0] wdata_in = '0;
  logic        tick_in = 1'b0;
  logic        play_in = 1'b0;
  logic        clr_in = 1'b0;
  logic        irq_ack_in = 1'b0;
  logic [47:0] audio_out;
  logic        valid_out;
  logic [11:0] level_out;
  logic [1:0]  full_out;
  logic [1:0]  empty_out;
  logic [1:0]  ovf_out;
  logic        nodata_out;
  logic        req_out;

  int checks = 0;
  int failures = 0;
  logic [47:0] exp_q [$];

  audio_fifo_bank #(
    .CHANNELS(2), .DATA_WIDTH(24), .FIFO_DEPTH(60), .IRQ_THRESHOLD(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_in(wr_in), .wdata_in(wdata_in),
    .tick_in(tick_in), .play_in(play_in), .clr_in(clr_in),
    .irq_ack_in(irq_ack_in), .audio_out(audio_out), .valid_out(valid_out),
    .level_out(level_out), .full_out(full_out), .empty_out(empty_out),
    .ovf_out(ovf_out), .nodata_out(nodata_out), .req_out(req_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL frame_unexpected got=%h", audio_out);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        if (audio_out !== e) begin
          failures++;
          $display("FAIL frame got=%h exp=%h", audio_out, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] wr, input logic [23:0] d0,
                     input logic [23:0] d1, input logic tk,
                     input logic cl, input logic ak);
    wr_in = wr;
    wdata_in = {d1, d0};
    tick_in = tk;
    clr_in = cl;
    irq_ack_in = ak;
    @(posedge clk);
    #1;
    wr_in = '0;
    tick_in = 1'b0;
    clr_in = 1'b0;
    irq_ack_in = 1'b0;
  endtask

  function automatic logic [5:0] lv(input int c);
    return level_out[c*6 +: 6];
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 64'(level_out), 0);
    chk("rst_empty", 64'(empty_out), 3);
    chk("rst_full", 64'(full_out), 0);
    chk("rst_flags", 64'({ovf_out, nodata_out, req_out, valid_out}), 0);
    chk("rst_audio", 64'(audio_out), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: fill, then drain with play
    for (int i = 1; i <= 60; i++)
      cyc(2'b11, 24'(i), 24'h100000 + 24'(i), 1'b0, 1'b0, 1'b0);
    chk("t1_full", 64'(full_out), 3);
    chk("t1_lvl0", 64'(lv(0)), 60);
    chk("t1_lvl1", 64'(lv(1)), 60);
    play_in = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      exp_q.push_back({24'h100000 + 24'(i), 24'(i)});
      cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
      if (i == 29) chk("t1_req_before", 64'(req_out), 0);
      if (i == 30) chk("t1_req_at_30", 64'(req_out), 1);
    end
    chk("t1_empty", 64'(empty_out), 3);
    chk("t1_lvl_end", 64'(level_out), 0);
    cyc(2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("t1_ack", 64'(req_out), 0);

    // 2: underrun, then an ignored tick with play low
    for (int i = 1; i <= 5; i++)
      cyc(2'b01, 24'h0F0000 + 24'(i), 0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(48'h0);
    cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("t2_nodata", 64'(nodata_out), 1);
    chk("t2_audio", 64'(audio_out), 0);
    chk("t2_lvl0", 64'(lv(0)), 5);
    play_in = 1'b0;
    cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("t2_nplay_valid", 64'(valid_out), 0);
    chk("t2_nplay_lvl0", 64'(lv(0)), 5);
    play_in = 1'b1;
    cyc(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("t2_clr_nodata", 64'(nodata_out), 0);

    // 3: overflow on full, then write+tick on full
    for (int i = 1; i <= 60; i++)
      cyc(2'b11, 24'h200000 + 24'(i), 24'h300000 + 24'(i), 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 24'hDEAD00, 24'hBEEF00, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf", 64'(ovf_out), 3);
    chk("t3_lvl", 64'(level_out), {6'd60, 6'd60});
    exp_q.push_back({24'h300001, 24'h200001});
    cyc(2'b11, 24'h2000AA, 24'h3000AA, 1'b1, 1'b0, 1'b0);
    chk("t3_ovf_keep", 64'(ovf_out), 3);
    chk("t3_lvl_keep", 64'(level_out), {6'd60, 6'd60});
    chk("t3_full", 64'(full_out), 3);
    chk("t3_req", 64'(req_out), 0);
    cyc(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("t3_clr_ovf", 64'(ovf_out), 0);

    // 4: streaming through the pointer wrap
    cyc(2'b11, 24'h400001, 24'h800001, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 64; k++) begin
      exp_q.push_back({24'h800000 + 24'(k - 1), 24'h400000 + 24'(k - 1)});
      cyc(2'b11, 24'h400000 + 24'(k), 24'h800000 + 24'(k), 1'b1, 1'b0, 1'b0);
    end
    chk("t4_lvl_stream", 64'(level_out), {6'd1, 6'd1});
    exp_q.push_back({24'h800040, 24'h400040});
    cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("t4_empty", 64'(empty_out), 3);

    // 5: clear beats write, tick and ack
    exp_q.push_back(48'h0);
    cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++)
      cyc(2'b11, 24'hA00000 + 24'(i), 24'hB00000 + 24'(i), 1'b0, 1'b0, 1'b0);
    exp_q.push_back({24'hB00001, 24'hA00001});
    cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("t5_pre_lvl", 64'(level_out), {6'd2, 6'd2});
    cyc(2'b11, 24'h123456, 24'h654321, 1'b1, 1'b1, 1'b1);
    chk("t5_lvl", 64'(level_out), 0);
    chk("t5_empty", 64'(empty_out), 3);
    chk("t5_flags", 64'({ovf_out, nodata_out, req_out}), 0);
    chk("t5_valid", 64'(valid_out), 0);
    chk("t5_audio", 64'(audio_out), 0);

    // 6: async reset while a valid pulse is in flight
    cyc(2'b11, 24'hC00001, 24'hD00001, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 24'hC00002, 24'hD00002, 1'b0, 1'b0, 1'b0);
    wr_in = 2'b11;
    wdata_in = {24'hD00003, 24'hC00003};
    tick_in = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid_inflight", 64'(valid_out), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(valid_out), 0);
    chk("t6_rst_audio", 64'(audio_out), 0);
    chk("t6_rst_lvl", 64'(level_out), 0);
    chk("t6_rst_empty", 64'(empty_out), 3);
    wr_in = '0;
    tick_in = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(2'b11, 24'hE00001, 24'hF00001, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({24'hF00001, 24'hE00001});
    cyc(2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("t6_lvl_after", 64'(level_out), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
